// File: rtl/urv_defs.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding and
// round-robin turn values.
package urv_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_WAIT = 2'd1,
    H_WAIT = 2'd2
  } arb_state_t;

  localparam logic FETCH = 1'b0;
  localparam logic HOST  = 1'b1;

endpackage

// File: rtl/urv_imem_arbiter.sv
// Instruction-memory arbiter: shares one memory port between the fetch unit
// and a host/debug loader, one transaction in flight, round-robin between the
// two. Fetch responses whose address no longer matches the live fetch address
// are dropped.
module urv_imem_arbiter
  import urv_defs::*;
#(
  parameter int g_addr_width = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // fetch side
  input  logic                    f_req_i,
  input  logic [g_addr_width-1:0] f_addr_i,
  output logic [31:0]             im_data_o,
  output logic                    im_valid_o,
  // host side
  input  logic                    h_req_i,
  input  logic                    h_we_i,
  input  logic [g_addr_width-1:0] h_addr_i,
  input  logic [31:0]             h_wdata_i,
  output logic                    h_ack_o,
  output logic [31:0]             h_rdata_o,
  // memory side
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [g_addr_width-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i,
  input  logic                    mem_valid_i
);

  arb_state_t              state_q, state_d;
  logic                    turn_q, turn_d;
  logic [g_addr_width-1:0] f_addr_q;
  logic                    sel_host;
  logic                    fetch_issue;
  logic                    host_done;

  // Fetch data passes straight through; only the valid is qualified.
  assign im_data_o = mem_rdata_i;

  // Next-state, issue mux and response qualification.
  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = f_addr_i;
    mem_wdata_o = '0;
    im_valid_o  = 1'b0;
    fetch_issue = 1'b0;
    host_done   = 1'b0;
    // Host wins when it is alone, or when both ask and it holds the turn.
    sel_host    = h_req_i && (!f_req_i || (turn_q == HOST));

    case (state_q)
      IDLE: begin
        if (f_req_i || h_req_i) begin
          mem_req_o = 1'b1;
          if (sel_host) begin
            mem_we_o    = h_we_i;
            mem_addr_o  = h_addr_i;
            mem_wdata_o = h_wdata_i;
            state_d     = H_WAIT;
          end else begin
            fetch_issue = 1'b1;
            state_d     = F_WAIT;
          end
        end
      end
      F_WAIT: begin
        if (mem_valid_i) begin
          // A branch while in flight makes the returning word stale.
          im_valid_o = (f_addr_q == f_addr_i) && f_req_i;
          state_d    = IDLE;
          turn_d     = HOST;
        end
      end
      H_WAIT: begin
        if (mem_valid_i) begin
          host_done = 1'b1;
          state_d   = IDLE;
          turn_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, turn, captured fetch address and registered host response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      turn_q    <= FETCH;
      f_addr_q  <= '0;
      h_ack_o   <= 1'b0;
      h_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      h_ack_o <= host_done;
      if (fetch_issue) f_addr_q  <= f_addr_i;
      if (host_done)   h_rdata_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_urv_imem_arbiter.sv
// Self-checking bench for urv_imem_arbiter: memory responder with
// configurable latency, a transaction-level reference model and per-scenario
// tasks.
module tb_urv_imem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i, f_req_i, h_req_i, h_we_i, mem_valid_i;
  logic [31:0] f_addr_i, h_addr_i, h_wdata_i, mem_rdata_i;
  logic [31:0] im_data_o, h_rdata_o, mem_addr_o, mem_wdata_o;
  logic        im_valid_o, h_ack_o, mem_req_o, mem_we_o;

  always #5 clk_i = ~clk_i;

  urv_imem_arbiter #(.g_addr_width(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i),
    .im_data_o(im_data_o), .im_valid_o(im_valid_o),
    .h_req_i(h_req_i), .h_we_i(h_we_i), .h_addr_i(h_addr_i),
    .h_wdata_i(h_wdata_i), .h_ack_o(h_ack_o), .h_rdata_o(h_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_valid_i(mem_valid_i)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // values driven on the next cycle
  bit          d_rst;
  logic        d_f_req, d_h_req, d_h_we;
  logic [31:0] d_f_addr, d_h_addr, d_h_wdata;

  // memory responder
  logic [31:0] ram [logic [31:0]];
  bit          pend_v;
  int          pend_cnt;
  logic [31:0] pend_d;
  int          lat_fix;     // 0 = random 1..5
  bit          t_outst;     // a transaction was outstanding this cycle
  bit          t_resp;

  // observed outputs
  logic        o_req, o_we, o_imv, o_ack;
  logic [31:0] o_addr, o_wdata, o_imd, o_hrd;

  // reference model: which requester is being served, who was served last
  int          m_busy;      // 0 none, 1 fetch, 2 host
  bit          m_last_host;
  logic [31:0] m_faddr, m_hrd;
  bit          m_ack_pend;
  logic        e_req, e_we, e_imv, e_ack, e_host;
  logic [31:0] e_addr, e_hrd;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic tick();
    bit selh;
    @(negedge clk_i);
    rst_i = d_rst; f_req_i = d_f_req; f_addr_i = d_f_addr;
    h_req_i = d_h_req; h_we_i = d_h_we; h_addr_i = d_h_addr; h_wdata_i = d_h_wdata;
    t_outst = pend_v;
    t_resp  = pend_v && pend_cnt == 0;
    if (pend_v && pend_cnt > 0) pend_cnt--;
    mem_valid_i = t_resp;
    mem_rdata_i = t_resp ? pend_d : $urandom;
    #1;
    o_req = mem_req_o; o_we = mem_we_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o;
    o_imv = im_valid_o; o_imd = im_data_o; o_ack = h_ack_o; o_hrd = h_rdata_o;
    // expectations for this cycle
    selh   = d_h_req && (!d_f_req || !m_last_host);
    e_req  = (m_busy == 0) && (d_f_req || d_h_req);
    e_host = selh;
    e_we   = e_req && selh && d_h_we;
    e_addr = selh ? d_h_addr : d_f_addr;
    e_imv  = (m_busy == 1) && t_resp && d_f_req && (d_f_addr == m_faddr);
    e_ack  = m_ack_pend;
    e_hrd  = m_hrd;
    // memory side effects
    if (t_resp) pend_v = 0;
    if (o_req && !d_rst) begin
      if (o_we) ram[o_addr] = o_wdata;
      pend_v   = 1;
      pend_cnt = (lat_fix > 0 ? lat_fix : int'($urandom_range(1, 5))) - 1;
      pend_d   = word(o_addr);
    end
    // model update
    if (d_rst) begin
      m_busy = 0; m_last_host = 1; m_ack_pend = 0; m_hrd = '0; m_faddr = '0;
    end else begin
      m_ack_pend = 0;
      if (t_resp && m_busy == 1) begin
        m_busy = 0; m_last_host = 0;
      end else if (t_resp && m_busy == 2) begin
        m_busy = 0; m_last_host = 1; m_ack_pend = 1; m_hrd = mem_rdata_i;
      end else if (e_req) begin
        m_busy = selh ? 2 : 1;
        if (!selh) m_faddr = d_f_addr;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    bit done = 0;
    d_f_req = 0; d_h_req = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (!pend_v && m_busy == 0) done = 1;
    end
    tick();
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL drain: transaction still outstanding after 20 cycles"); end
  endtask

  task automatic test_reset();
    d_rst = 1; d_f_req = 0; d_h_req = 0; d_h_we = 0;
    d_f_addr = '0; d_h_addr = '0; d_h_wdata = '0;
    tick(); tick();
    d_rst = 0;
    tick();
    n_cmp += 5;
    if (o_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", o_req); end
    if (o_we  !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", o_we); end
    if (o_imv !== 1'b0) begin n_bad++; $display("FAIL reset_im_valid: got %b want 0", o_imv); end
    if (o_ack !== 1'b0) begin n_bad++; $display("FAIL reset_h_ack: got %b want 0", o_ack); end
    if (o_hrd !== 32'h0) begin n_bad++; $display("FAIL reset_h_rdata: got %h want 0", o_hrd); end
  endtask

  task automatic test_fetch_only();
    int k = 0, last_iss = -1;
    lat_fix = 1; d_f_req = 1; d_f_addr = 32'h0; d_h_req = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      tick();
      if (o_req) begin
        n_cmp += 2;
        if (o_addr !== d_f_addr || o_we !== 1'b0) begin
          n_bad++; $display("FAIL fetch_issue: addr %h we %b want addr %h we 0", o_addr, o_we, d_f_addr);
        end
        if (last_iss >= 0 && cyc - last_iss != 2) begin
          n_bad++; $display("FAIL fetch_spacing: got %0d cycles want 2", cyc - last_iss);
        end
        last_iss = cyc;
      end
      if (o_imv) begin
        n_cmp += 2;
        if (d_f_addr !== 32'(k * 4)) begin n_bad++; $display("FAIL fetch_order: got addr %h want %h", d_f_addr, k * 4); end
        if (o_imd !== word(d_f_addr)) begin n_bad++; $display("FAIL fetch_data: got %h want %h", o_imd, word(d_f_addr)); end
        k++; d_f_addr = d_f_addr + 32'd4;
      end
    end
    n_cmp++;
    if (k != 3) begin n_bad++; $display("FAIL fetch_timeout: got %0d valids want 3", k); end
    drain();
  endtask

  task automatic test_branch();
    bit reiss = 0, got = 0;
    int iss0;
    lat_fix = 3; d_f_req = 1; d_f_addr = 32'h10; d_h_req = 0;
    tick();
    iss0 = cyc;
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== 32'h10) begin
      n_bad++; $display("FAIL branch_issue: req %b addr %h want req 1 addr 00000010", o_req, o_addr);
    end
    d_f_addr = 32'h80;
    for (int c = 0; c < 15 && !got; c++) begin
      tick();
      if (o_req) begin
        n_cmp += 2;
        if (o_addr !== 32'h80) begin n_bad++; $display("FAIL branch_reissue_addr: got %h want 00000080", o_addr); end
        if (cyc - iss0 != 4) begin n_bad++; $display("FAIL branch_reissue_time: got %0d want 4", cyc - iss0); end
        reiss = 1;
      end
      if (o_imv) begin
        n_cmp++;
        if (!reiss) begin n_bad++; $display("FAIL branch_stale_valid: got valid data %h want none", o_imd); end
        else if (o_imd !== word(32'h80)) begin n_bad++; $display("FAIL branch_data: got %h want %h", o_imd, word(32'h80)); end
        else got = 1;
      end
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL branch_timeout: got no valid for 00000080 want one"); end
    drain();
  endtask

  task automatic test_host_wr_rd();
    int acks = 0;
    lat_fix = 2; d_f_req = 1; d_f_addr = 32'h0;
    for (int op = 0; op < 2; op++) begin
      bit seen = 0;
      d_h_req = 1; d_h_we = (op == 0); d_h_addr = 32'h100;
      d_h_wdata = (op == 0) ? 32'hDEADBEEF : 32'h12345678;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        n_cmp++;
        if (o_imv !== e_imv) begin n_bad++; $display("FAIL host_im_valid: got %b want %b", o_imv, e_imv); end
        if (o_imv) begin
          n_cmp++;
          if (o_imd !== word(d_f_addr)) begin n_bad++; $display("FAIL host_fetch_data: got %h want %h", o_imd, word(d_f_addr)); end
          d_f_addr = (d_f_addr + 32'd4) & 32'h3C;
        end
        if (o_ack) begin
          seen = 1; acks++;
          if (op == 1) begin
            n_cmp++;
            if (o_hrd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL host_rdata: got %h want deadbeef", o_hrd); end
          end
        end
      end
      d_h_req = 0;
      tick();
      n_cmp++;
      if (o_ack !== 1'b0) begin n_bad++; $display("FAIL host_ack_pulse: got %b want 0", o_ack); end
      if (o_imv) d_f_addr = (d_f_addr + 32'd4) & 32'h3C;
    end
    n_cmp++;
    if (acks != 2) begin n_bad++; $display("FAIL host_ack_count: got %0d want 2", acks); end
    drain();
  endtask

  task automatic test_alternation();
    int n = 0;
    bit own;
    lat_fix = 2;
    d_rst = 1; d_f_req = 0; d_h_req = 0; tick(); d_rst = 0;
    d_f_req = 1; d_f_addr = 32'h0; d_h_req = 1; d_h_we = 0; d_h_addr = 32'h200;
    for (int c = 0; c < 80 && n < 8; c++) begin
      tick();
      if (o_req) begin
        own = (o_addr == 32'h200);
        n_cmp++;
        if (own !== (n % 2 == 1)) begin
          n_bad++; $display("FAIL alt_owner #%0d: got %s want %s", n, own ? "H" : "F", (n % 2 == 1) ? "H" : "F");
        end
        n++;
      end
      if (o_imv) d_f_addr = (d_f_addr + 32'd4) & 32'h3C;
      if (o_ack) d_h_req = 0;
      else if (!d_h_req) d_h_req = 1;
    end
    n_cmp++;
    if (n < 8) begin n_bad++; $display("FAIL alt_timeout: got %0d issues want 8", n); end
    drain();
  endtask

  task automatic test_reset_hwait();
    lat_fix = 3; d_f_req = 0; d_h_req = 1; d_h_we = 0; d_h_addr = 32'h300;
    tick();
    n_cmp++;
    if (o_req !== 1'b1 || o_addr !== 32'h300) begin
      n_bad++; $display("FAIL rsth_issue: req %b addr %h want req 1 addr 00000300", o_req, o_addr);
    end
    d_h_req = 0; d_rst = 1;
    tick(); tick();
    d_rst = 0; d_f_req = 1; d_f_addr = 32'h40; d_h_req = 1;
    tick();
    n_cmp += 4;
    if (t_resp !== 1'b1) begin n_bad++; $display("FAIL rsth_late_valid: got %b want 1", t_resp); end
    if (o_ack !== 1'b0) begin n_bad++; $display("FAIL rsth_ack: got %b want 0", o_ack); end
    if (o_hrd !== 32'h0) begin n_bad++; $display("FAIL rsth_rdata: got %h want 0", o_hrd); end
    if (o_req !== 1'b1 || o_addr !== 32'h40 || o_we !== 1'b0) begin
      n_bad++; $display("FAIL rsth_next_fetch: req %b addr %h we %b want 1 00000040 0", o_req, o_addr, o_we);
    end
    tick();
    n_cmp++;
    if (o_ack !== 1'b0) begin n_bad++; $display("FAIL rsth_ack_late: got %b want 0", o_ack); end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] refm [logic [31:0]];
    int reqs = 0, acks = 0, gap = 0;
    bit h_out = 0;
    logic [31:0] rv;
    lat_fix = 0; d_f_req = 1; d_f_addr = 32'h0; d_h_req = 0;
    for (int c = 0; c < 1500 + 40 && (c < 1500 || h_out); c++) begin
      if (!h_out && gap == 0 && c < 1500) begin
        h_out = 1; reqs++;
        d_h_req = 1; d_h_we = $urandom_range(0, 1);
        d_h_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        d_h_wdata = $urandom;
      end
      tick();
      n_cmp += 4;
      if (o_req !== e_req) begin n_bad++; $display("FAIL rnd_req @%0d: got %b want %b", cyc, o_req, e_req); end
      if (o_imv !== e_imv) begin n_bad++; $display("FAIL rnd_im_valid @%0d: got %b want %b", cyc, o_imv, e_imv); end
      if (o_ack !== e_ack) begin n_bad++; $display("FAIL rnd_ack @%0d: got %b want %b", cyc, o_ack, e_ack); end
      if (o_req && t_outst) begin n_bad++; $display("FAIL rnd_req_outstanding @%0d: got req 1 want 0", cyc); end
      if (o_req) begin
        n_cmp++;
        if (o_addr !== e_addr || o_we !== e_we) begin
          n_bad++; $display("FAIL rnd_issue @%0d: addr %h we %b want addr %h we %b", cyc, o_addr, o_we, e_addr, e_we);
        end
      end
      if (o_imv) begin
        n_cmp++;
        if (o_imd !== word(d_f_addr)) begin n_bad++; $display("FAIL rnd_fetch_data @%0d: got %h want %h", cyc, o_imd, word(d_f_addr)); end
        d_f_addr = (d_f_addr + 32'd4) & 32'h3FC;
      end
      if ($urandom_range(0, 7) == 0) d_f_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if (gap > 0) gap--;
      if (o_ack) begin
        acks++;
        n_cmp++;
        if (!h_out) begin n_bad++; $display("FAIL rnd_dup_ack @%0d: got ack with no request", cyc); end
        if (d_h_we) refm[d_h_addr] = d_h_wdata;
        else begin
          rv = refm.exists(d_h_addr) ? refm[d_h_addr] : word(d_h_addr);
          n_cmp++;
          if (o_hrd !== rv) begin n_bad++; $display("FAIL rnd_rdata @%0d: got %h want %h", cyc, o_hrd, rv); end
        end
        h_out = 0; d_h_req = 0; gap = $urandom_range(1, 4);
      end
    end
    n_cmp++;
    if (acks != reqs) begin n_bad++; $display("FAIL rnd_ack_count: got %0d want %0d", acks, reqs); end
    drain();
  endtask

  initial begin
    pend_v = 0; pend_cnt = 0; pend_d = '0; lat_fix = 1;
    m_busy = 0; m_last_host = 1; m_ack_pend = 0; m_hrd = '0; m_faddr = '0;
    rst_i = 1; f_req_i = 0; h_req_i = 0; h_we_i = 0; mem_valid_i = 0;
    f_addr_i = '0; h_addr_i = '0; h_wdata_i = '0; mem_rdata_i = '0;
    test_reset();
    test_fetch_only();
    test_branch();
    test_host_wr_rd();
    test_alternation();
    test_reset_hwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/urv_imem_arbiter.md
# urv_imem_arbiter

Shares the single instruction-memory port between the fetch stage and a host/debug loader port. Only one memory transaction is outstanding at a time. Requesters alternate round-robin. Fetch responses are dropped when the fetch address moves, for example on a branch, while the read is in flight. The block sits between the fetch unit's `im_*` port and the instruction RAM.

## Interface
- `g_addr_width`, default 32: width of every address port.
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `f_req_i`  in  1  fetch wants a word; high continuously once the core is out of reset.
- `f_addr_i`  in  g_addr_width  fetch address; may change on any cycle.
- `im_data_o`  out  32  fetch read data; valid only while `im_valid_o` is high.
- `im_valid_o`  out  1  one-cycle pulse: `im_data_o` is the word at the current `f_addr_i`.
- `h_req_i`  in  1  host access request; held high until `h_ack_o`.
- `h_we_i`  in  1  1 = write, 0 = read.
- `h_addr_i`  in  g_addr_width  host address; stable while `h_req_i` is high.
- `h_wdata_i`  in  32  host write data.
- `h_ack_o`  out  1  one-cycle pulse, registered: host access complete.
- `h_rdata_o`  out  32  host read data; valid with `h_ack_o`.
- `mem_req_o`  out  1  one-cycle issue strobe to memory.
- `mem_we_o`  out  1  write enable, qualified by `mem_req_o`.
- `mem_addr_o`  out  g_addr_width  memory address.
- `mem_wdata_o`  out  32  memory write data.
- `mem_rdata_i`  in  32  memory read data.
- `mem_valid_i`  in  1  response or write-done; arrives at least 1 cycle after the issue.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - F_WAIT: fetch read outstanding.
  - H_WAIT: host access outstanding.
- `turn` register: 0 = fetch has priority, 1 = host has priority.
- In IDLE, a requester is selected when at least one request is high:
  - Only one requester high: select it.
  - Both high: select the requester named by `turn`.
- Issue (combinational, IDLE only):
  - `mem_req_o` = 1.
  - Mux the selected requester onto `mem_addr_o`, `mem_we_o` and `mem_wdata_o`.
  - `mem_we_o` = 0 for fetch.
  - The next state is F_WAIT or H_WAIT.
- When fetch is issued, `f_addr_i` is captured in `f_addr_q`.
- F_WAIT with `mem_valid_i`:
  - `im_valid_o` = (`f_addr_q` == `f_addr_i`) && `f_req_i`, combinational.
  - `im_data_o` = `mem_rdata_i`.
  - A mismatch drops the response silently.
  - Next state IDLE; `turn` <= 1.
- H_WAIT with `mem_valid_i`:
  - Register `h_ack_o` <= 1.
  - Register `h_rdata_o` <= `mem_rdata_i`; this is don't-care for a write, but is still loaded.
  - Next state IDLE; `turn` <= 0.
- `mem_valid_i` in IDLE is ignored. This covers a stray response that arrives after reset.
- With no response, a WAIT state is held indefinitely; the block has no timeout.
- `mem_req_o` is never asserted in a WAIT state.

## Timing
- Reset values:
  - State IDLE, `turn` 0, `f_addr_q` 0.
  - `h_ack_o` 0, `h_rdata_o` 0.
  - `im_valid_o`, `mem_req_o` and `mem_we_o` read 0 the cycle after reset is released, when there are no requests.
- Fetch latency: the issue is cycle N and the response is cycle N+L, where L ≥ 1. `im_valid_o` is in cycle N+L, with no added register stage. The next issue is at the earliest in cycle N+L+1.
- Host latency: the issue is cycle N and `mem_valid_i` is cycle N+L. `h_ack_o` is in cycle N+L+1. The host may drop `h_req_i` in cycle N+L+2; the block does not re-issue in N+L+1 because `turn` is now 0 and fetch has priority. The host must drop `h_req_i` no later than the cycle after `h_ack_o`, otherwise the request is treated as a new one.
- Both requesters continuously active: issues alternate F, H, F, H. Each requester gets at least 1 of every 2 transactions.
- Reset asserted mid-transaction: the next state is IDLE, the outstanding response is discarded, and no ack or valid is generated for it.

## Structure
- Shared package `urv_defs` holds:
  - the FSM state encoding: IDLE = 2'd0, F_WAIT = 2'd1, H_WAIT = 2'd2;
  - the `turn` constants, FETCH = 1'b0 and HOST = 1'b1.
- Single module with no sub-modules. The round-robin selector is 2-way, which is too small to split out.

## Test plan
- Fetch only, L = 1, addresses 0x0, 0x4, 0x8: each `im_valid_o` carries the matching RAM word. An issue happens every 2nd cycle.
- Branch during F_WAIT: 0x10 is issued, `f_addr_i` becomes 0x80 before the response → no `im_valid_o`. The next issue is to 0x80 and is then valid.
- Host write of 0xDEADBEEF to 0x100, then host read of 0x100: `h_ack_o` is pulsed twice and the read gives `h_rdata_o` = 0xDEADBEEF. No spurious `im_valid_o` occurs.
- Both requesting continuously: the `mem_req_o` owner sequence is F, H, F, H. The host is never starved beyond 1 fetch transaction.
- Reset in H_WAIT, with a late `mem_valid_i` the cycle after reset is released: no `h_ack_o`, state IDLE, and the next issue is fetch (`turn` = 0).
- Random latency 1–5 with mixed traffic: scoreboard shows every `h_ack_o` exactly once per request. `mem_req_o` is never high with an outstanding transaction.
